riscv_decoder: RTL and testbench

Combinational RV32I main decoder for the single-cycle core. It sits between instruction fetch and the datapath. It turns each fetched 32-bit instruction into operand-select, ALU-op, LSU and writeback controls plus an illegal-instruction flag. A small registered side path keeps a sticky record of any illegal instruction decoded since reset.

---
 rtl/riscv_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_riscv_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_decoder.sv
// riscv_decoder: combinational RV32I main decoder with a registered sticky
// flag that records whether any illegal instruction was decoded since reset.
module riscv_decoder (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] fetched_instr_i,
    output logic [1:0]  ex_op_a_sel_o,
    output logic [2:0]  ex_op_b_sel_o,
    output logic [4:0]  alu_op_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [2:0]  mem_size_o,
    output logic        gpr_we_a_o,
    output logic        wb_src_sel_o,
    output logic        illegal_instr_o,
    output logic        branch_o,
    output logic        jal_o,
    output logic        jalr_o,
    output logic        illegal_seen_o
);

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [1:0] OP_A_RS1  = 2'b00;
    localparam logic [1:0] OP_A_PC   = 2'b01;
    localparam logic [1:0] OP_A_ZERO = 2'b10;

    localparam logic [2:0] OP_B_RS2  = 3'b000;
    localparam logic [2:0] OP_B_IMMI = 3'b001;
    localparam logic [2:0] OP_B_IMMU = 3'b010;
    localparam logic [2:0] OP_B_IMMS = 3'b011;
    localparam logic [2:0] OP_B_INCR = 3'b100;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_LTS  = 5'b11100;
    localparam logic [4:0] ALU_LTU  = 5'b11110;
    localparam logic [4:0] ALU_GES  = 5'b11101;
    localparam logic [4:0] ALU_GEU  = 5'b11111;
    localparam logic [4:0] ALU_EQ   = 5'b11000;
    localparam logic [4:0] ALU_NE   = 5'b11001;
    localparam logic [4:0] ALU_SLTS = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;

    localparam logic [2:0] SIZE_W = 3'b010;

    logic [4:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       illegal_seen_q;
    logic       illegal_seen_d;

    assign op = fetched_instr_i[6:2];
    assign f3 = fetched_instr_i[14:12];
    assign f7 = fetched_instr_i[31:25];

    // Main decode: defaults first, per-opcode overrides, then illegal squash.
    always_comb begin
        ex_op_a_sel_o   = OP_A_RS1;
        ex_op_b_sel_o   = OP_B_IMMI;
        alu_op_o        = ALU_ADD;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_size_o      = SIZE_W;
        gpr_we_a_o      = 1'b0;
        wb_src_sel_o    = 1'b0;
        illegal_instr_o = 1'b0;
        branch_o        = 1'b0;
        jal_o           = 1'b0;
        jalr_o          = 1'b0;

        if (fetched_instr_i[1:0] != 2'b11) begin
            illegal_instr_o = 1'b1;
        end else begin
            case (op)
                OPC_LOAD: begin
                    mem_req_o    = 1'b1;
                    mem_size_o   = f3;
                    wb_src_sel_o = 1'b1;
                    gpr_we_a_o   = 1'b1;
                    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) illegal_instr_o = 1'b1;
                end
                OPC_MISC_MEM: begin
                    if (f3 != 3'd0) illegal_instr_o = 1'b1;
                end
                OPC_OP_IMM: begin
                    gpr_we_a_o = 1'b1;
                    case (f3)
                        3'd0: alu_op_o = ALU_ADD;
                        3'd1: begin
                            alu_op_o = ALU_SLL;
                            if (f7 != 7'h00) illegal_instr_o = 1'b1;
                        end
                        3'd2: alu_op_o = ALU_SLTS;
                        3'd3: alu_op_o = ALU_SLTU;
                        3'd4: alu_op_o = ALU_XOR;
                        3'd5: begin
                            if (f7 == 7'h00)      alu_op_o = ALU_SRL;
                            else if (f7 == 7'h20) alu_op_o = ALU_SRA;
                            else                  illegal_instr_o = 1'b1;
                        end
                        3'd6: alu_op_o = ALU_OR;
                        default: alu_op_o = ALU_AND;
                    endcase
                end
                OPC_AUIPC: begin
                    ex_op_a_sel_o = OP_A_PC;
                    ex_op_b_sel_o = OP_B_IMMU;
                    gpr_we_a_o    = 1'b1;
                end
                OPC_STORE: begin
                    ex_op_b_sel_o = OP_B_IMMS;
                    mem_req_o     = 1'b1;
                    mem_we_o      = 1'b1;
                    mem_size_o    = f3;
                    if (f3 > 3'd2) illegal_instr_o = 1'b1;
                end
                OPC_OP: begin
                    ex_op_b_sel_o = OP_B_RS2;
                    gpr_we_a_o    = 1'b1;
                    case ({f7, f3})
                        {7'h00, 3'd0}: alu_op_o = ALU_ADD;
                        {7'h20, 3'd0}: alu_op_o = ALU_SUB;
                        {7'h00, 3'd1}: alu_op_o = ALU_SLL;
                        {7'h00, 3'd2}: alu_op_o = ALU_SLTS;
                        {7'h00, 3'd3}: alu_op_o = ALU_SLTU;
                        {7'h00, 3'd4}: alu_op_o = ALU_XOR;
                        {7'h00, 3'd5}: alu_op_o = ALU_SRL;
                        {7'h20, 3'd5}: alu_op_o = ALU_SRA;
                        {7'h00, 3'd6}: alu_op_o = ALU_OR;
                        {7'h00, 3'd7}: alu_op_o = ALU_AND;
                        default:       illegal_instr_o = 1'b1;
                    endcase
                end
                OPC_LUI: begin
                    ex_op_a_sel_o = OP_A_ZERO;
                    ex_op_b_sel_o = OP_B_IMMU;
                    gpr_we_a_o    = 1'b1;
                end
                OPC_BRANCH: begin
                    ex_op_b_sel_o = OP_B_RS2;
                    branch_o      = 1'b1;
                    case (f3)
                        3'd0:    alu_op_o = ALU_EQ;
                        3'd1:    alu_op_o = ALU_NE;
                        3'd4:    alu_op_o = ALU_LTS;
                        3'd5:    alu_op_o = ALU_GES;
                        3'd6:    alu_op_o = ALU_LTU;
                        3'd7:    alu_op_o = ALU_GEU;
                        default: illegal_instr_o = 1'b1;
                    endcase
                end
                OPC_JALR: begin
                    ex_op_a_sel_o = OP_A_PC;
                    ex_op_b_sel_o = OP_B_INCR;
                    gpr_we_a_o    = 1'b1;
                    jalr_o        = 1'b1;
                    if (f3 != 3'd0) illegal_instr_o = 1'b1;
                end
                OPC_JAL: begin
                    ex_op_a_sel_o = OP_A_PC;
                    ex_op_b_sel_o = OP_B_INCR;
                    gpr_we_a_o    = 1'b1;
                    jal_o         = 1'b1;
                end
                OPC_SYSTEM: begin
                    // Only ECALL (all upper bits zero) is accepted, as a NOP.
                    if (fetched_instr_i[31:7] != 25'd0) illegal_instr_o = 1'b1;
                end
                default: illegal_instr_o = 1'b1;
            endcase
        end

        // An illegal word must not cause side effects: fall back to defaults.
        if (illegal_instr_o) begin
            ex_op_a_sel_o = OP_A_RS1;
            ex_op_b_sel_o = OP_B_IMMI;
            alu_op_o      = ALU_ADD;
            mem_req_o     = 1'b0;
            mem_we_o      = 1'b0;
            mem_size_o    = SIZE_W;
            gpr_we_a_o    = 1'b0;
            wb_src_sel_o  = 1'b0;
            branch_o      = 1'b0;
            jal_o         = 1'b0;
            jalr_o        = 1'b0;
        end
    end

    assign illegal_seen_d = illegal_seen_q | illegal_instr_o;

    // Sticky illegal record; only a reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) illegal_seen_q <= 1'b0;
        else         illegal_seen_q <= illegal_seen_d;
    end

    assign illegal_seen_o = illegal_seen_q;

endmodule

// File: tb/tb_riscv_decoder.sv
// tb_riscv_decoder: scoreboard bench for the RV32I decoder and sticky flag.
module tb_riscv_decoder;

    // ---------------- clock / reset ----------------
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] fetched_instr_i = 32'h0000_0013;
    logic [1:0]  ex_op_a_sel_o;
    logic [2:0]  ex_op_b_sel_o;
    logic [4:0]  alu_op_o;
    logic        mem_req_o, mem_we_o;
    logic [2:0]  mem_size_o;
    logic        gpr_we_a_o, wb_src_sel_o, illegal_instr_o;
    logic        branch_o, jal_o, jalr_o, illegal_seen_o;

    always #5 clk_i = ~clk_i;

    riscv_decoder dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .fetched_instr_i (fetched_instr_i),
        .ex_op_a_sel_o   (ex_op_a_sel_o),
        .ex_op_b_sel_o   (ex_op_b_sel_o),
        .alu_op_o        (alu_op_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_size_o      (mem_size_o),
        .gpr_we_a_o      (gpr_we_a_o),
        .wb_src_sel_o    (wb_src_sel_o),
        .illegal_instr_o (illegal_instr_o),
        .branch_o        (branch_o),
        .jal_o           (jal_o),
        .jalr_o          (jalr_o),
        .illegal_seen_o  (illegal_seen_o)
    );

    // ---------------- scoreboard ----------------
    localparam int W = 21;
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (instr %h)", tag, obs, exp, fetched_instr_i);
        end
    endtask

    // Reference table: packed {a, b, alu, req, we, size, gwe, wb, ill, br, jal, jalr}
    function automatic logic [W-1:0] model(input logic [31:0] w);
        logic [4:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [1:0] a;
        logic [2:0] b, size;
        logic [4:0] alu;
        logic req, we, gwe, wb, ill, br, jl, jr;
        op = w[6:2]; f3 = w[14:12]; f7 = w[31:25];
        a = 2'b00; b = 3'b001; alu = 5'b00000; size = 3'b010;
        req = 0; we = 0; gwe = 0; wb = 0; ill = 0; br = 0; jl = 0; jr = 0;
        if (w[1:0] != 2'b11) ill = 1;
        else if (op == 5'b00000) begin
            req = 1; size = f3; wb = 1; gwe = 1;
            ill = (f3 == 3) || (f3 == 6) || (f3 == 7);
        end else if (op == 5'b00011) ill = (f3 != 0);
        else if (op == 5'b00100) begin
            gwe = 1;
            case (f3)
                0: alu = 5'b00000;
                1: begin alu = 5'b00001; ill = (f7 != 0); end
                2: alu = 5'b00010;
                3: alu = 5'b00011;
                4: alu = 5'b00100;
                5: begin alu = (f7 == 7'h20) ? 5'b01101 : 5'b00101; ill = !(f7 == 0 || f7 == 7'h20); end
                6: alu = 5'b00110;
                default: alu = 5'b00111;
            endcase
        end else if (op == 5'b00101) begin a = 2'b01; b = 3'b010; gwe = 1; end
        else if (op == 5'b01000) begin
            b = 3'b011; req = 1; we = 1; size = f3; ill = (f3 > 2);
        end else if (op == 5'b01100) begin
            b = 3'b000; gwe = 1;
            if (f7 == 0) begin
                case (f3)
                    0: alu = 5'b00000; 1: alu = 5'b00001; 2: alu = 5'b00010; 3: alu = 5'b00011;
                    4: alu = 5'b00100; 5: alu = 5'b00101; 6: alu = 5'b00110; default: alu = 5'b00111;
                endcase
            end else if (f7 == 7'h20 && f3 == 0) alu = 5'b01000;
            else if (f7 == 7'h20 && f3 == 5) alu = 5'b01101;
            else ill = 1;
        end else if (op == 5'b01101) begin a = 2'b10; b = 3'b010; gwe = 1; end
        else if (op == 5'b11000) begin
            b = 3'b000; br = 1;
            case (f3)
                0: alu = 5'b11000; 1: alu = 5'b11001; 4: alu = 5'b11100;
                5: alu = 5'b11101; 6: alu = 5'b11110; 7: alu = 5'b11111;
                default: ill = 1;
            endcase
        end else if (op == 5'b11001) begin a = 2'b01; b = 3'b100; gwe = 1; jr = 1; ill = (f3 != 0); end
        else if (op == 5'b11011) begin a = 2'b01; b = 3'b100; gwe = 1; jl = 1; end
        else if (op == 5'b11100) ill = (w[31:7] != 0);
        else ill = 1;
        if (ill) begin
            a = 2'b00; b = 3'b001; alu = 5'b00000; size = 3'b010;
            req = 0; we = 0; gwe = 0; wb = 0; br = 0; jl = 0; jr = 0;
        end
        return {a, b, alu, req, we, size, gwe, wb, ill, br, jl, jr};
    endfunction

    function automatic logic [W-1:0] observed();
        return {ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o, mem_req_o, mem_we_o, mem_size_o,
                gpr_we_a_o, wb_src_sel_o, illegal_instr_o, branch_o, jal_o, jalr_o};
    endfunction

    // ---------------- driver ----------------
    task automatic drive_vec(input logic [31:0] w);
        @(negedge clk_i);
        fetched_instr_i = w;
        exp_q.push_back(model(w));
        #1;
        if (exp_q.size() == 0) check_eq("sb_empty", 32'd0, 32'd1);
        else check_eq("decode", 32'(observed()), 32'(exp_q.pop_front()));
    endtask

    // Random word with the given opcode, biased toward legal f7 / ECALL.
    task automatic drive_rand_op(input logic [4:0] op);
        logic [31:0] r;
        int sel;
        r = $urandom();
        sel = $urandom_range(0, 3);
        if (sel == 0) r[31:25] = 7'h00;
        if (sel == 1) r[31:25] = 7'h20;
        if (sel == 2 && op == 5'b11100) r[31:7] = 25'd0;
        r[6:0] = {op, 2'b11};
        drive_vec(r);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] r;
        // reset state
        #3;
        check_eq("seen_reset", 32'(illegal_seen_o), 32'd0);
        // illegal word while held in reset must not set the flag
        fetched_instr_i = 32'hFFFF_FFFF;
        @(posedge clk_i); #1;
        check_eq("seen_in_reset", 32'(illegal_seen_o), 32'd0);
        // release reset together with an illegal word
        @(negedge clk_i);
        rst_ni = 1'b1;
        fetched_instr_i = 32'h0000_0000;
        @(posedge clk_i); #1;
        check_eq("seen_set", 32'(illegal_seen_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive_vec(32'h00C5_8533);
            @(posedge clk_i); #1;
            check_eq("seen_hold", 32'(illegal_seen_o), 32'd1);
        end
        // asynchronous clear mid-cycle
        @(negedge clk_i); #2;
        rst_ni = 1'b0;
        #1;
        check_eq("seen_async_clr", 32'(illegal_seen_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        fetched_instr_i = 32'h0000_0013;
        @(posedge clk_i); #1;
        check_eq("seen_stay_clr", 32'(illegal_seen_o), 32'd0);

        // directed vectors
        drive_vec(32'h00C5_8533);
        check_eq("add_a", 32'(ex_op_a_sel_o), 32'd0);
        check_eq("add_b", 32'(ex_op_b_sel_o), 32'd0);
        check_eq("add_alu", 32'(alu_op_o), 32'b00000);
        check_eq("add_gwe", 32'(gpr_we_a_o), 32'd1);
        check_eq("add_req", 32'(mem_req_o), 32'd0);
        drive_vec(32'h40C5_8533);
        check_eq("sub_alu", 32'(alu_op_o), 32'b01000);
        drive_vec(32'h02C5_8533);
        check_eq("op_f7_ill", 32'(illegal_instr_o), 32'd1);
        check_eq("op_f7_gwe", 32'(gpr_we_a_o), 32'd0);
        drive_vec(32'h0000_A503);
        check_eq("lw_req", 32'(mem_req_o), 32'd1);
        check_eq("lw_we", 32'(mem_we_o), 32'd0);
        check_eq("lw_size", 32'(mem_size_o), 32'b010);
        check_eq("lw_wb", 32'(wb_src_sel_o), 32'd1);
        drive_vec(32'h0000_B503);
        check_eq("ld3_ill", 32'(illegal_instr_o), 32'd1);
        check_eq("ld3_req", 32'(mem_req_o), 32'd0);
        drive_vec(32'h0000_A023);
        check_eq("sw_we", 32'(mem_we_o), 32'd1);
        check_eq("sw_b", 32'(ex_op_b_sel_o), 32'b011);
        check_eq("sw_gwe", 32'(gpr_we_a_o), 32'd0);
        drive_vec(32'h0000_00EF);
        check_eq("jal_jal", 32'(jal_o), 32'd1);
        check_eq("jal_a", 32'(ex_op_a_sel_o), 32'b01);
        check_eq("jal_b", 32'(ex_op_b_sel_o), 32'b100);
        drive_vec(32'h0000_1067);
        check_eq("jalr_f3_ill", 32'(illegal_instr_o), 32'd1);
        drive_vec(32'h0000_0073);
        check_eq("ecall_ill", 32'(illegal_instr_o), 32'd0);
        check_eq("ecall_gwe", 32'(gpr_we_a_o), 32'd0);
        drive_vec(32'h0010_0073);
        check_eq("ebreak_ill", 32'(illegal_instr_o), 32'd1);
        drive_vec(32'h1234_50B7);
        check_eq("lui_a", 32'(ex_op_a_sel_o), 32'b10);
        check_eq("lui_b", 32'(ex_op_b_sel_o), 32'b010);
        check_eq("lui_alu", 32'(alu_op_o), 32'b00000);
        drive_vec(32'h0000_2063);
        check_eq("br2_ill", 32'(illegal_instr_o), 32'd1);
        check_eq("br2_branch", 32'(branch_o), 32'd0);

        // per-opcode sweep
        for (int op = 0; op < 32; op++)
            for (int i = 0; i < 500; i++)
                drive_rand_op(5'(op));
        // fully random words; low bits != 11 must be illegal
        for (int i = 0; i < 2000; i++) begin
            r = $urandom();
            drive_vec(r);
            if (r[1:0] != 2'b11) check_eq("lowbits_ill", 32'(illegal_instr_o), 32'd1);
        end
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
